// File: rtl/palette_pkg.sv
// Shared constants and FSM encoding for the palette controller.
// RGB_BIT comes from the `RGB_BIT macro (default 12). Optional fade feature: PALETTE_FADE_EN.
`ifndef RGB_BIT
`define RGB_BIT 12
`endif

package palette_pkg;
    localparam int PAL_RGB_BIT = `RGB_BIT;
    localparam int PAL_NPAL    = 4;
    localparam int PAL_NCOL    = 4;
    // Address split: cpu_wr_addr = {palette[1:0], colour[1:0]}
    localparam int PAL_IDX_W   = 2;
    localparam int COL_IDX_W   = 2;
    localparam int ENT_IDX_W   = PAL_IDX_W + COL_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2,
        ST_DONE  = 2'd3
    } pal_state_e;
endpackage

// File: rtl/palette_arb.sv
// Two-requester lookup arbiter: sprite has priority, except that a bg
// requester denied in the previous cycle wins the next contested cycle.
module palette_arb
    import palette_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bg_req_i,
    input  logic                 sp_req_i,
    input  logic [PAL_IDX_W-1:0] bg_pal_i,
    input  logic [PAL_IDX_W-1:0] sp_pal_i,
    output logic                 bg_gnt_o,
    output logic                 sp_gnt_o,
    output logic [PAL_IDX_W-1:0] gnt_pal_o
);
    logic bg_starve_q, bg_starve_d;

    // Grant decision and starve flag next-state
    always_comb begin
        bg_gnt_o    = bg_req_i & (~sp_req_i | bg_starve_q);
        sp_gnt_o    = sp_req_i & ~bg_gnt_o;
        gnt_pal_o   = sp_gnt_o ? sp_pal_i : bg_pal_i;
        bg_starve_d = bg_starve_q;
        if (bg_gnt_o) begin
            bg_starve_d = 1'b0;
        end else if (bg_req_i) begin
            bg_starve_d = 1'b1;
        end
    end

    // Starve flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            bg_starve_q <= 1'b0;
        end else begin
            bg_starve_q <= bg_starve_d;
        end
    end
endmodule

// File: rtl/palette_ctrl.sv
// Palette table: CPU-written shadow bank, vblank-synchronised copy into the
// active bank, and an arbitrated 1-cycle lookup port for bg/sprite pipelines.
// Optional macro PALETTE_FADE_EN adds fade_lvl, a per-channel right shift applied during copy.
module palette_ctrl
    import palette_pkg::*;
#(
    parameter int RGB_BIT = PAL_RGB_BIT,
    parameter int NPAL    = PAL_NPAL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vblank,
    input  logic                 cpu_wr_en,
    input  logic [ENT_IDX_W-1:0] cpu_wr_addr,
    input  logic [RGB_BIT-1:0]   cpu_wr_data,
    input  logic                 cpu_commit,
`ifdef PALETTE_FADE_EN
    input  logic [1:0]           fade_lvl,
`endif
    output logic                 cpu_busy,
    output logic                 commit_done,
    input  logic                 bg_req,
    input  logic                 sp_req,
    input  logic [PAL_IDX_W-1:0] bg_pal,
    input  logic [PAL_IDX_W-1:0] sp_pal,
    output logic                 bg_gnt,
    output logic                 sp_gnt,
    output logic                 rd_valid,
    output logic                 rd_owner,
    output logic [RGB_BIT-1:0]   rd_color00,
    output logic [RGB_BIT-1:0]   rd_color01,
    output logic [RGB_BIT-1:0]   rd_color10,
    output logic [RGB_BIT-1:0]   rd_color11
);
    localparam int NENT = NPAL * PAL_NCOL;

    logic [RGB_BIT-1:0]   shadow_q [NENT];
    logic [RGB_BIT-1:0]   active_q [NENT];
    logic [RGB_BIT-1:0]   rd_color_q [PAL_NCOL];
    logic                 rd_valid_q, rd_owner_q;
    logic                 vblank_q, vblank_rise;
    pal_state_e           state_q, state_d;
    logic [ENT_IDX_W-1:0] idx_q, idx_d;
    logic                 rearm_q, rearm_d;
    logic [PAL_IDX_W-1:0] gnt_pal;
    logic [RGB_BIT-1:0]   copy_word;

    assign vblank_rise = vblank & ~vblank_q;

`ifdef PALETTE_FADE_EN
    localparam int CH_W = RGB_BIT / 3;
    logic [1:0] fade_q;

    function automatic logic [RGB_BIT-1:0] fade_word(input logic [RGB_BIT-1:0] w,
                                                     input logic [1:0] lvl);
        logic [RGB_BIT-1:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            r[c*CH_W +: CH_W] = w[c*CH_W +: CH_W] >> lvl;
        end
        return r;
    endfunction

    // Fade level is captured once on the COPY entry edge and held for the whole copy
    always_ff @(posedge clk) begin
        if (rst) begin
            fade_q <= 2'd0;
        end else if (state_q == ST_ARMED && vblank_rise) begin
            fade_q <= fade_lvl;
        end
    end

    assign copy_word = fade_word(shadow_q[idx_q], fade_q);
`else
    assign copy_word = shadow_q[idx_q];
`endif

    palette_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .bg_req_i  (bg_req),
        .sp_req_i  (sp_req),
        .bg_pal_i  (bg_pal),
        .sp_pal_i  (sp_pal),
        .bg_gnt_o  (bg_gnt),
        .sp_gnt_o  (sp_gnt),
        .gnt_pal_o (gnt_pal)
    );

    // Copy FSM next-state: commit arms, vblank rise starts the 16-entry copy
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rearm_d = rearm_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_commit) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (vblank_rise) begin
                    state_d = ST_COPY;
                    idx_d   = '0;
                end
            end
            ST_COPY: begin
                idx_d = idx_q + 1'b1;
                if (cpu_commit) rearm_d = 1'b1;
                if (idx_q == ENT_IDX_W'(NENT - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = rearm_q ? ST_ARMED : ST_IDLE;
                rearm_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cpu_busy    = (state_q == ST_COPY);
    assign commit_done = (state_q == ST_DONE);

    // FSM state, copy index, rearm flag and vblank edge register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rearm_q  <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rearm_q  <= rearm_d;
            vblank_q <= vblank;
        end
    end

    // Shadow bank: CPU writes land here except while a copy is running
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) shadow_q[i] <= '0;
        end else if (cpu_wr_en && state_q != ST_COPY) begin
            shadow_q[cpu_wr_addr] <= cpu_wr_data;
        end
    end

    // Active bank: one entry per cycle copied from shadow during COPY
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) active_q[i] <= '0;
        end else if (state_q == ST_COPY) begin
            active_q[idx_q] <= copy_word;
        end
    end

    // Lookup register: the granted palette's four colours appear one cycle after grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_owner_q <= 1'b0;
            for (int i = 0; i < PAL_NCOL; i++) rd_color_q[i] <= '0;
        end else begin
            rd_valid_q <= bg_gnt | sp_gnt;
            if (bg_gnt | sp_gnt) begin
                rd_owner_q <= sp_gnt;
                for (int i = 0; i < PAL_NCOL; i++) begin
                    rd_color_q[i] <= active_q[{gnt_pal, COL_IDX_W'(i)}];
                end
            end
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_owner   = rd_owner_q;
    assign rd_color00 = rd_color_q[0];
    assign rd_color01 = rd_color_q[1];
    assign rd_color10 = rd_color_q[2];
    assign rd_color11 = rd_color_q[3];
endmodule

// File: tb/tb_palette_ctrl.sv
// Self-checking bench for palette_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model of the palette table.
module tb_palette_ctrl;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst, vblank, cpu_wr_en, cpu_commit, bg_req, sp_req;
    logic [3:0] cpu_wr_addr;
    logic [W-1:0] cpu_wr_data;
    logic [1:0] bg_pal, sp_pal;
    logic [1:0] fade_in;
    logic cpu_busy, commit_done, bg_gnt, sp_gnt, rd_valid, rd_owner;
    logic [W-1:0] rd_color00, rd_color01, rd_color10, rd_color11;

    always #5 clk = ~clk;

    palette_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vblank      (vblank),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_commit  (cpu_commit),
`ifdef PALETTE_FADE_EN
        .fade_lvl    (fade_in),
`endif
        .cpu_busy    (cpu_busy),
        .commit_done (commit_done),
        .bg_req      (bg_req),
        .sp_req      (sp_req),
        .bg_pal      (bg_pal),
        .sp_pal      (sp_pal),
        .bg_gnt      (bg_gnt),
        .sp_gnt      (sp_gnt),
        .rd_valid    (rd_valid),
        .rd_owner    (rd_owner),
        .rd_color00  (rd_color00),
        .rd_color01  (rd_color01),
        .rd_color10  (rd_color10),
        .rd_color11  (rd_color11)
    );

    // Reference model state
    int m_shadow[16];
    int m_active[16];
    bit m_pending, m_rearm, m_done_pulse, m_vb_prev, m_starve;
    int m_left;  // copy cycles still to run (0 = not copying)
    int m_fade;
    bit e_valid, e_owner;
    int e_col[4];

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Each of the three channels shifted right by lvl, computed arithmetically
    function automatic int fade_ref(input int w, input int lvl);
        int base, scale, res, ch;
        base = 1 << (W / 3);
        scale = 1;
        res = 0;
        for (int k = 0; k < 3; k++) begin
            ch = (w / scale) % base;
            res += (ch >> lvl) * scale;
            scale *= base;
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
        m_pending = 0; m_rearm = 0; m_done_pulse = 0; m_vb_prev = 0; m_starve = 0;
        m_left = 0; m_fade = 0;
        e_valid = 0; e_owner = 0;
        for (int i = 0; i < 4; i++) e_col[i] = 0;
    endtask

    // One clock: inputs are already set (at negedge); returns at the next negedge
    task automatic cycle();
        bit eb, es, vrise, copying;
        int pal, idx;
        #1;
        eb = bg_req && (!sp_req || m_starve);
        es = sp_req && !eb;
        check("bg_gnt", bg_gnt, eb);
        check("sp_gnt", sp_gnt, es);
        check("cpu_busy", cpu_busy, m_left > 0);
        check("commit_done", commit_done, m_done_pulse);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            vrise = vblank && !m_vb_prev;
            e_valid = eb || es;
            if (eb || es) begin
                e_owner = es;
                pal = es ? int'(sp_pal) : int'(bg_pal);
                for (int i = 0; i < 4; i++) e_col[i] = m_active[pal * 4 + i];
            end
            copying = m_left > 0;
            if (m_done_pulse) begin
                m_done_pulse = 0;
                m_pending = m_rearm;
                m_rearm = 0;
            end else if (copying) begin
                idx = 16 - m_left;
                m_active[idx] = fade_ref(m_shadow[idx], m_fade);
                if (cpu_commit) m_rearm = 1;
                m_left--;
                if (m_left == 0) m_done_pulse = 1;
            end else if (m_pending) begin
                if (vrise) begin
                    m_pending = 0;
                    m_left = 16;
`ifdef PALETTE_FADE_EN
                    m_fade = int'(fade_in);
`else
                    m_fade = 0;
`endif
                end
            end else if (cpu_commit) begin
                m_pending = 1;
            end
            if (cpu_wr_en && !copying) m_shadow[cpu_wr_addr] = int'(cpu_wr_data);
            m_vb_prev = vblank;
            if (eb) m_starve = 0;
            else if (bg_req) m_starve = 1;
        end
        #1;
        check("rd_valid", rd_valid, e_valid);
        check("rd_owner", rd_owner, e_owner);
        check("rd_color00", rd_color00, e_col[0]);
        check("rd_color01", rd_color01, e_col[1]);
        check("rd_color10", rd_color10, e_col[2]);
        check("rd_color11", rd_color11, e_col[3]);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_wr_en = 0; cpu_commit = 0; bg_req = 0; sp_req = 0;
    endtask

    // Run n cycles, counting busy cycles and done pulses seen after each edge
    task automatic run_count(input int n, output int busy_cnt, output int done_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (cpu_busy) busy_cnt++;
            if (commit_done) done_cnt++;
        end
    endtask

    initial begin
        int bc, dc;
        int own[3];
        rst = 1; vblank = 0; cpu_wr_en = 0; cpu_commit = 0; bg_req = 0; sp_req = 0;
        cpu_wr_addr = 0; cpu_wr_data = 0; bg_pal = 0; sp_pal = 0; fade_in = 0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        cycle();
        check("reset_busy", cpu_busy, 0);
        check("reset_valid", rd_valid, 0);
        rst = 0;

        // Lookup after reset: palette 2 is all zero
        bg_req = 1; bg_pal = 2;
        cycle();
        idle_inputs();
        check("t1_valid", rd_valid, 1);
        check("t1_owner", rd_owner, 0);
        check("t1_col00", rd_color00, 0);
        check("t1_col11", rd_color11, 0);

        // Write, commit, vblank rise 10 cycles later, copy of 16 cycles
        cpu_wr_en = 1; cpu_wr_addr = 4; cpu_wr_data = 12'hF00;
        cycle();
        cpu_wr_en = 0; cpu_commit = 1;
        cycle();
        cpu_commit = 0;
        run_count(10, bc, dc);
        check("t2_no_early_busy", bc, 0);
        vblank = 1;
        run_count(24, bc, dc);
        check("t2_busy_cycles", bc, 16);
        check("t2_done_pulses", dc, 1);
        vblank = 0;
        bg_req = 1; bg_pal = 1;
        cycle();
        idle_inputs();
        check("t2_col00", rd_color00, 12'hF00);

        // Contested requests: sp, bg, sp
        bg_req = 1; sp_req = 1; bg_pal = 3; sp_pal = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            own[i] = int'(rd_owner);
        end
        idle_inputs();
        check("t3_owner0", own[0], 1);
        check("t3_owner1", own[1], 0);
        check("t3_owner2", own[2], 1);

        // Write dropped during COPY, and a commit during COPY rearms
        cycle();
        cpu_commit = 1;
        cycle();
        cpu_commit = 0; vblank = 1;
        cycle();
        vblank = 1; cpu_wr_en = 1; cpu_wr_addr = 0; cpu_wr_data = 12'h123;
        cycle();
        check("t4_busy_at_write", cpu_busy, 1);
        cpu_wr_en = 0; cpu_commit = 1;
        cycle();
        cpu_commit = 0;
        run_count(20, bc, dc);
        check("t5_first_done", dc, 1);
        run_count(5, bc, dc);
        check("t5_wait_rise", bc, 0);
        vblank = 0;
        cycle();
        vblank = 1;
        run_count(24, bc, dc);
        check("t5_second_busy", bc, 16);
        check("t5_second_done", dc, 1);
        vblank = 0;
        bg_req = 1; bg_pal = 0;
        cycle();
        idle_inputs();
        check("t4_col00_dropped", rd_color00, 0);

`ifdef PALETTE_FADE_EN
        // Fade by one: 0xF84 -> 0x742
        cpu_wr_en = 1; cpu_wr_addr = 5; cpu_wr_data = 12'hF84;
        cycle();
        cpu_wr_en = 0; cpu_commit = 1;
        cycle();
        cpu_commit = 0; vblank = 1; fade_in = 1;
        cycle();
        fade_in = 3;
        run_count(20, bc, dc);
        vblank = 0; fade_in = 0;
        bg_req = 1; bg_pal = 1;
        cycle();
        idle_inputs();
        check("fade_col01", rd_color01, 12'h742);
`endif

        // Reset in the middle of a copy aborts it without commit_done
        cpu_wr_en = 1; cpu_wr_addr = 9; cpu_wr_data = 12'hABC;
        cycle();
        cpu_wr_en = 0; cpu_commit = 1;
        cycle();
        cpu_commit = 0; vblank = 1;
        run_count(6, bc, dc);
        check("abort_busy_before", cpu_busy, 1);
        rst = 1;
        cycle();
        rst = 0;
        run_count(20, bc, dc);
        check("abort_no_done", dc, 0);
        check("abort_no_busy", bc, 0);
        vblank = 0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 19) == 0) vblank = ~vblank;
            cpu_wr_en = ($urandom_range(0, 2) == 0);
            cpu_wr_addr = 4'($urandom);
            cpu_wr_data = 12'($urandom);
            cpu_commit = ($urandom_range(0, 24) == 0);
            bg_req = 1'($urandom);
            sp_req = 1'($urandom);
            bg_pal = 2'($urandom);
            sp_pal = 2'($urandom);
            fade_in = 2'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
